bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that shares one 4:1 datapath multiplexer (e.g. the shared register-file write-back or memory-address path) among four requesters. It grants one requester at a time, drives the mux select pair, and holds the grant until the owner signals completion, drops its request, or a watchdog expires. It sits in the RISC control path between requesting units and the `Mux4b` instance whose `s1`/`s2` inputs it drives.

## Interface
- `HOLD_MAX`, 15: maximum cycles a grant may be held before forced release (2..255).
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req`  input  4  request per requester; bit i = requester i.
- `done`  input  4  completion strobe; only the bit of the current owner is honoured.
- `gnt`  output  4  one-hot grant, registered; all-zero when idle.
- `s1`  output  1  mux select LSB (= owner index bit 0).
- `s2`  output  1  mux select MSB (= owner index bit 1).
- `busy`  output  1  high while a grant is active.
- `timeout`  output  1  one-cycle pulse on watchdog-forced release.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any `req` bit set, pick winner by round-robin starting at pointer `ptr`; scan order `ptr, ptr+1, ... , ptr+3` mod 4. Next cycle: BUSY, `gnt` = one-hot(winner), `{s2,s1}` = winner, `busy`=1, hold counter = 0.
- IDLE with `req`=0: stay IDLE; `gnt`=0, `busy`=0, `{s2,s1}` holds last owner index (mux input stays stable).
- BUSY, release when any of: `done[owner]`=1; `req[owner]`=0; hold counter = `HOLD_MAX`-1. On release: next cycle IDLE, `gnt`=0, `busy`=0, `ptr` = owner+1 mod 4.
- Watchdog release only (no `done`, `req` still high): `timeout`=1 for exactly the IDLE cycle following release.
- `done` bits of non-owners ignored; `done` in IDLE ignored.
- Simultaneous `done[owner]` and counter expiry: treated as normal completion, `timeout` stays 0.
- Hold counter width: ceil(log2(HOLD_MAX)); increments each BUSY cycle, saturates never (release precedes wrap).
- Pointer wrap: owner 3 releases, `ptr` becomes 0.
- Reset (`rst_n`=0 at any edge, including mid-grant): next cycle IDLE, `gnt`=0, `s1`=`s2`=0, `busy`=0, `timeout`=0, `ptr`=0, counter=0; the in-flight grant is abandoned.

## Timing
- Grant latency: `req` seen in IDLE at edge t → `gnt` valid after edge t+1.
- Release latency: release condition at edge t → `gnt`=0 after edge t+1.
- One mandatory IDLE turnaround cycle between consecutive grants; back-to-back grants are spaced at least one cycle apart with `gnt`=0 in between.
- `{s2,s1}` change only on the same edge `gnt` asserts; never change while `busy`=1.
- All outputs registered; no combinational path from `req`/`done` to any output.
- Maximum grant duration: `HOLD_MAX` cycles.

## Structure
- Shared package `arb_pkg`: state encoding (`ARB_IDLE`=1'b0, `ARB_BUSY`=1'b1), `N_REQ`=4, `SEL_W`=2.
- Sub-module `rr_picker`: combinational; inputs `req[3:0]`, `ptr[1:0]`; outputs `valid`, `idx[1:0]`. Top holds FSM, pointer, hold counter, output registers.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `req`=4'b1111 → `gnt`=0, `s1`=`s2`=0, `busy`=0; first grant after release goes to requester 0.
- Round-robin fairness: `req`=4'b1111 held, each owner pulses `done` one cycle after grant → grant order 0,1,2,3,0 with `gnt`=0 one cycle between each.
- Request drop: grant to requester 2 (`{s2,s1}`=2'b10), drop `req[2]` after 3 cycles → `gnt`=0 next cycle, `{s2,s1}` stays 2'b10, next grant to 3 if requested.
- Watchdog: `HOLD_MAX`=4, `req`=4'b0010 held, no `done` → `gnt`=4'b0010 for exactly 4 cycles, then `timeout`=1 for one cycle, then requester 1 re-granted.
- Foreign/simultaneous `done`: owner 1, `done`=4'b1000 → no release; `done[1]` coincident with expiry → release with `timeout`=0.
- Reset mid-grant: owner 3 busy, `rst_n` low one cycle → all outputs reset next cycle, `ptr`=0, first subsequent grant to lowest pending index.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings and sizes for the round-robin bus arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N_REQ.
module rr_picker
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    // Walk from the farthest offset back toward ptr so the nearest hit is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared 4:1 mux: grants one requester, drives {s2,s1}, and
// releases on done, request drop, or watchdog expiry.
module bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             s1,
  output logic             s2,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             expire;
  logic             owner_done;
  logic             owner_req;

  rr_picker u_rr_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign expire     = (cnt_q == CNT_LAST);
  assign owner_done = done[sel_q];
  assign owner_req  = req[sel_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d         = ARB_BUSY;
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          cnt_d           = '0;
        end
      end
      ARB_BUSY: begin
        if (owner_done || !owner_req || expire) begin
          state_d   = ARB_IDLE;
          gnt_d     = '0;
          ptr_d     = sel_q + SEL_W'(1);
          // A coincident done wins over the watchdog: that is a normal completion.
          timeout_d = expire && !owner_done && owner_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign s1      = sel_q[0];
  assign s2      = sel_q[1];
  assign busy    = (state_q == ARB_BUSY);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (HOLD_MAX 15 and 4) share stimulus and are
// compared every cycle against a cycle-count model plus directed scenario checks.
module tb_bus_arbiter;

  localparam int HOLD_A = 15;
  localparam int HOLD_B = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;

  logic [3:0] gnt_a, gnt_b;
  logic       s1_a, s2_a, busy_a, to_a;
  logic       s1_b, s2_b, busy_b, to_b;

  int n_checks;
  int n_fail;

  // Model state per instance: busy flag, owner/last owner, pointer, cycles held so far.
  int m_busy[2];
  int m_sel[2];
  int m_ptr[2];
  int m_held[2];
  int m_to[2];
  int m_lim[2] = '{HOLD_A, HOLD_B};
  int m_found;
  int m_win;

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_MAX(HOLD_A)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt_a),
    .s1      (s1_a),
    .s2      (s2_a),
    .busy    (busy_a),
    .timeout (to_a)
  );

  bus_arbiter #(.HOLD_MAX(HOLD_B)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt_b),
    .s1      (s1_b),
    .s2      (s2_b),
    .busy    (busy_b),
    .timeout (to_b)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 0;
      if (!rst_n) begin
        m_busy[k] = 0;
        m_sel[k]  = 0;
        m_ptr[k]  = 0;
        m_held[k] = 0;
      end else if (m_busy[k] != 0) begin
        if (done[m_sel[k]] || !req[m_sel[k]] || m_held[k] == m_lim[k]) begin
          m_to[k]   = (m_held[k] == m_lim[k] && !done[m_sel[k]] && req[m_sel[k]]) ? 1 : 0;
          m_busy[k] = 0;
          m_ptr[k]  = (m_sel[k] + 1) % 4;
        end else begin
          m_held[k] = m_held[k] + 1;
        end
      end else begin
        m_found = 0;
        m_win   = 0;
        for (int j = 0; j < 4; j++) begin
          if (m_found == 0 && req[(m_ptr[k] + j) % 4]) begin
            m_found = 1;
            m_win   = (m_ptr[k] + j) % 4;
          end
        end
        if (m_found != 0) begin
          m_busy[k] = 1;
          m_sel[k]  = m_win;
          m_held[k] = 1;
        end
      end
    end
  end

  function automatic logic [7:0] obs(int k);
    if (k == 0) return {gnt_a, s2_a, s1_a, busy_a, to_a};
    return {gnt_b, s2_b, s1_b, busy_b, to_b};
  endfunction

  function automatic logic [7:0] exp_vec(int k);
    logic [3:0] g;
    logic [1:0] s;
    g = (m_busy[k] != 0) ? 4'(1 << m_sel[k]) : 4'b0000;
    s = 2'(m_sel[k]);
    return {g, s[1], s[0], m_busy[k] != 0, m_to[k] != 0};
  endfunction

  task automatic restart(input logic [3:0] r);
    req   = r;
    done  = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL reset_model dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_vec(k));
        end
      end
      if (c <= 2) begin
        n_checks++;
        if ({gnt_a, s2_a, s1_a, busy_a, to_a} !== 8'b0) begin
          n_fail++;
          $display("FAIL reset_outputs cyc%0d: got %b want 00000000", c,
                   {gnt_a, s2_a, s1_a, busy_a, to_a});
        end
      end else begin
        n_checks++;
        if (gnt_a !== 4'b0001) begin
          n_fail++;
          $display("FAIL reset_first_grant: got %b want 0001", gnt_a);
        end
      end
      if (c == 2) rst_n = 1'b1;
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{1, 2, 4, 8, 1};
    restart(4'b1111);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL rr_model dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_vec(k));
        end
      end
      if (gnt_a != 4'b0000) begin
        order.push_back(int'(gnt_a));
        done = gnt_a;
      end else begin
        done = 4'b0000;
      end
    end
    done = 4'b0000;
    n_checks++;
    if (order.size() < 5) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d want >=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (order[i] != exp_order[i]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_req_drop();
    restart(4'b0100);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL drop_model dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_vec(k));
        end
      end
      n_checks++;
      if (c <= 3 && {gnt_a, s2_a, s1_a} !== 6'b0100_10) begin
        n_fail++;
        $display("FAIL drop_held cyc%0d: got %b want 010010", c, {gnt_a, s2_a, s1_a});
      end else if (c == 4 && {gnt_a, s2_a, s1_a} !== 6'b0000_10) begin
        n_fail++;
        $display("FAIL drop_release: got %b want 000010", {gnt_a, s2_a, s1_a});
      end else if (c == 5 && {gnt_a, s2_a, s1_a} !== 6'b1000_11) begin
        n_fail++;
        $display("FAIL drop_next_grant: got %b want 100011", {gnt_a, s2_a, s1_a});
      end
      if (c == 3) req = 4'b1000;
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] g[1:8];
    logic       t[1:8];
    restart(4'b0010);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL wd_model dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_vec(k));
        end
      end
      g[c] = gnt_b;
      t[c] = to_b;
    end
    for (int c = 1; c <= 6; c++) begin
      n_checks++;
      if (c <= 4 && {g[c], t[c]} !== 5'b0010_0) begin
        n_fail++;
        $display("FAIL wd_hold cyc%0d: got %b want 00100", c, {g[c], t[c]});
      end else if (c == 5 && {g[c], t[c]} !== 5'b0000_1) begin
        n_fail++;
        $display("FAIL wd_timeout: got %b want 00001", {g[c], t[c]});
      end else if (c == 6 && {g[c], t[c]} !== 5'b0010_0) begin
        n_fail++;
        $display("FAIL wd_regrant: got %b want 00100", {g[c], t[c]});
      end
    end
  endtask

  task automatic test_foreign_done();
    restart(4'b0010);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL fd_model dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_vec(k));
        end
      end
      n_checks++;
      if (c >= 2 && c <= 4 && {gnt_a, gnt_b} !== 8'b0010_0010) begin
        n_fail++;
        $display("FAIL fd_foreign_ignored cyc%0d: got %b want 00100010", c, {gnt_a, gnt_b});
      end else if (c == 5 && {gnt_a, gnt_b, to_a, to_b} !== 10'b0) begin
        n_fail++;
        $display("FAIL fd_done_at_expiry: got %b want 0000000000", {gnt_a, gnt_b, to_a, to_b});
      end
      done = (c <= 3) ? 4'b1000 : (c == 4) ? 4'b0010 : 4'b0000;
    end
    done = 4'b0000;
  endtask

  task automatic test_reset_mid_grant();
    restart(4'b1000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL rmg_model dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_vec(k));
        end
      end
      n_checks++;
      if (c == 1 && {gnt_a, s2_a, s1_a, busy_a} !== 7'b1000_111) begin
        n_fail++;
        $display("FAIL rmg_owner3: got %b want 1000111", {gnt_a, s2_a, s1_a, busy_a});
      end else if (c == 3 && {gnt_a, s2_a, s1_a, busy_a, to_a} !== 8'b0) begin
        n_fail++;
        $display("FAIL rmg_cleared: got %b want 00000000", {gnt_a, s2_a, s1_a, busy_a, to_a});
      end else if (c == 4 && gnt_a !== 4'b0010) begin
        n_fail++;
        $display("FAIL rmg_lowest_pending: got %b want 0010", gnt_a);
      end
      if (c == 2) begin
        rst_n = 1'b0;
        req   = 4'b1010;
      end else begin
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    restart(4'b0000);
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL rand_model dut%0d cyc%0d: got %b want %b", k, c, obs(k), exp_vec(k));
        end
      end
      // Bias toward long-held requests so watchdog expiry is exercised often.
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      done  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      rst_n = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1'b1;
    req   = 4'b0000;
    done  = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    done     = 4'b0000;
    test_reset();
    test_round_robin();
    test_req_drop();
    test_watchdog();
    test_foreign_done();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
